bcd_digit_scanner: RTL

BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

---
 rtl/bcd_digit_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_digit_scanner.sv
// bcd_digit_scanner
//
// Time-multiplexed driver for a four-digit common-anode 7-segment display.
// Each digit owns a slot of PRESCALE clock cycles. The first BLANK_CYCLES
// cycles of a slot keep all anodes off to suppress ghosting. The remaining
// cycles light the digit selected by idx. New display data is double
// buffered. A load while scanning lands in the shadow register and is
// committed only at a frame boundary, so a frame never mixes old and new
// digits.
//
// Optional build feature: define LEADING_ZERO_BLANK_EN to suppress leading
// zeros on digits 3..1. Digit 0 is always shown. When the macro is not
// defined, every digit is always shown.

module bcd_digit_scanner #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits_in,
    output logic [3:0]  digit_out,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        bad_digit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST   = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pend_q, pend_d;
    logic        bad_q, bad_d;

    logic [3:0]  cur_nib;
    logic        suppress;
    logic        nib_bad;
    logic        slot_end;
    logic        frame_end;

    // Select the nibble for the current slot and work out whether it is
    // suppressed as a leading zero or is not a legal BCD value.
    always_comb begin
        cur_nib = 4'h0;
        case (idx_q)
            2'd0: cur_nib = active_q[3:0];
            2'd1: cur_nib = active_q[7:4];
            2'd2: cur_nib = active_q[11:8];
            2'd3: cur_nib = active_q[15:12];
            default: cur_nib = 4'h0;
        endcase

        suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd3: suppress = (active_q[15:12] == 4'h0);
            2'd2: suppress = (active_q[15:8] == 8'h00);
            2'd1: suppress = (active_q[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
`endif

        nib_bad   = (cur_nib > 4'd9);
        slot_end  = (state_q == SHOW) && (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == 2'd3);
    end

    // Drive the display outputs purely from registered state. Anodes stay
    // off outside SHOW, and also for suppressed or invalid digits.
    always_comb begin
        an         = 4'b1111;
        digit_out  = 4'h0;
        frame_done = frame_end;
        bad_digit  = bad_q;
        if ((state_q == SHOW) && !suppress && !nib_bad) begin
            an        = ~(4'b0001 << idx_q);
            digit_out = cur_nib;
        end
    end

    // Compute the next slot state, advance the counters, and handle the
    // double-buffered data path and the sticky invalid-digit flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        active_d = active_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        bad_d    = bad_q;

        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 2'd0;
                if (en) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (slot_end) begin
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 2'd1;
                    state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 2'd0;
            end
        endcase

        // Dropping enable parks the scanner immediately. Any pending shadow
        // data is kept for the next frame boundary.
        if (!en) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            idx_d   = 2'd0;
        end

        // The flag is latched only for a digit that would actually be lit.
        // Suppressed leading zeros never reach this check.
        if ((state_q == SHOW) && !suppress && nib_bad) begin
            bad_d = 1'b1;
        end

        // While idle nothing is on screen, so a load can go straight to the
        // active register. It also drops any stale pending data so that the
        // newest value wins.
        if (load) begin
            if (state_q == IDLE) begin
                active_d = digits_in;
                pend_d   = 1'b0;
            end else begin
                shadow_d = digits_in;
                pend_d   = 1'b1;
            end
        end

        // Commit buffered data only at the end of the digit-3 slot. A load on
        // that same cycle bypasses the shadow so that it still takes effect
        // at this boundary.
        if (frame_end) begin
            if (load) begin
                active_d = digits_in;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                active_d = shadow_q;
                pend_d   = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 2'd0;
            active_q <= 16'h0000;
            shadow_q <= 16'h0000;
            pend_q   <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            bad_q    <= bad_d;
        end
    end

endmodule
